// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (F) and
// data (M) pipeline stages. Each access runs through a req/ready handshake,
// and stallF/stallM are held until that stage's access completes.
// Optional feature macro: ARB_IFETCH_BUF_EN adds a one-entry fetch buffer
// that answers repeated fetches of the same word without a memory access.
module mem_port_arbiter #(
   parameter int DPRIO = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_valid,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_memwrite,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        stallF,
   output logic        stallM,
   output logic        m_req,
   output logic [31:0] m_addr,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ready
);

   typedef enum logic [1:0] {IDLE, DACC, IACC} arbState_t;

   arbState_t   state;
   logic        iValidQ;
   logic        dValidQ;
   logic [31:0] iRdataQ;
   logic [31:0] dRdataQ;
   logic        iElig;
   logic        dElig;
   logic        pickD;
   logic        pickI;
   logic        dWe;
   logic [3:0]  dBe;
   logic [31:0] dWdata;
   logic        unusedOk;

   // Fetch addresses are always word aligned on the memory side.
   assign unusedOk = &{1'b0, i_addr[1:0]};

`ifdef ARB_IFETCH_BUF_EN
   logic [29:0] bufTag;
   logic [31:0] bufData;
   logic        bufValid;
   logic        iHit;

   // A hit answers the fetch in the same cycle regardless of FSM state.
   assign iHit    = i_req & bufValid & (i_addr[31:2] == bufTag);
   assign i_valid = iValidQ | iHit;
   assign i_rdata = iHit ? bufData : iRdataQ;

   // Fill the buffer on every fetch completion; drop it when a store hits the buffered word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bufTag   <= '0;
         bufData  <= '0;
         bufValid <= 1'b0;
      end else if (state == IACC && m_ready) begin
         bufTag   <= m_addr[31:2];
         bufData  <= m_rdata;
         bufValid <= 1'b1;
      end else if (state == DACC && m_ready && m_we && (m_addr[31:2] == bufTag)) begin
         bufValid <= 1'b0;
      end
   end
`else
   assign i_valid = iValidQ;
   assign i_rdata = iRdataQ;
`endif

   assign d_valid = dValidQ;
   assign d_rdata = dRdataQ;
   assign stallF  = i_req & ~i_valid;
   assign stallM  = d_req & ~d_valid;

   // A request seen during its own valid cycle is the one just served, so it is not eligible.
   always_comb begin
      iElig = i_req & ~i_valid;
      dElig = d_req & ~d_valid;
      pickD = dElig & (~iElig | (DPRIO != 0));
      pickI = iElig & ~pickD;
   end

   // Translate the memwrite code into write strobe, little-endian lanes and replicated data.
   always_comb begin
      dWe    = 1'b0;
      dBe    = 4'b1111;
      dWdata = d_wdata;
      case (d_memwrite)
         2'b01: begin
            dWe = 1'b1;
         end
         2'b10: begin
            dWe    = 1'b1;
            dBe    = d_addr[1] ? 4'b1100 : 4'b0011;
            dWdata = {2{d_wdata[15:0]}};
         end
         2'b11: begin
            dWe    = 1'b1;
            dBe    = 4'b0001 << d_addr[1:0];
            dWdata = {4{d_wdata[7:0]}};
         end
         default: begin
            dWe = 1'b0;
         end
      endcase
   end

   // Arbitration FSM: latch the winner's access fields, hold them until m_ready, then pulse valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_be    <= 4'b0000;
         m_addr  <= '0;
         m_wdata <= '0;
         iValidQ <= 1'b0;
         dValidQ <= 1'b0;
         iRdataQ <= '0;
         dRdataQ <= '0;
      end else begin
         iValidQ <= 1'b0;
         dValidQ <= 1'b0;
         case (state)
            IDLE: begin
               if (pickD) begin
                  state   <= DACC;
                  m_req   <= 1'b1;
                  m_addr  <= {d_addr[31:2], 2'b00};
                  m_we    <= dWe;
                  m_be    <= dBe;
                  m_wdata <= dWdata;
               end else if (pickI) begin
                  state   <= IACC;
                  m_req   <= 1'b1;
                  m_addr  <= {i_addr[31:2], 2'b00};
                  m_we    <= 1'b0;
                  m_be    <= 4'b1111;
                  m_wdata <= '0;
               end
            end
            DACC: begin
               if (m_ready) begin
                  state   <= IDLE;
                  m_req   <= 1'b0;
                  m_we    <= 1'b0;
                  dRdataQ <= m_rdata;
                  dValidQ <= 1'b1;
               end
            end
            IACC: begin
               if (m_ready) begin
                  state   <= IDLE;
                  m_req   <= 1'b0;
                  m_we    <= 1'b0;
                  iRdataQ <= m_rdata;
                  iValidQ <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. The bench plays
// the memory by driving m_ready/m_rdata itself; expected values are hand-derived.
// Define ARB_IFETCH_BUF_EN for both files to exercise the fetch buffer.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_valid;
   logic        d_req;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_memwrite;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        stallF;
   logic        stallM;
   logic        m_req;
   logic [31:0] m_addr;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ready;

   int total;
   int bad;

   mem_port_arbiter #(.DPRIO(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_valid    (i_valid),
      .d_req      (d_req),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_memwrite (d_memwrite),
      .d_rdata    (d_rdata),
      .d_valid    (d_valid),
      .stallF     (stallF),
      .stallM     (stallM),
      .m_req      (m_req),
      .m_addr     (m_addr),
      .m_we       (m_we),
      .m_be       (m_be),
      .m_wdata    (m_wdata),
      .m_rdata    (m_rdata),
      .m_ready    (m_ready)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Move to the next cycle and settle 2 ns past the rising edge before driving/sampling.
   task automatic applyStimulus();
      @(posedge clk);
      #2;
   endtask

   // One comparison of an observed DUT value against a hand-computed value.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed sequence of steps.
   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      i_req      = 1'b0;
      i_addr     = '0;
      d_req      = 1'b0;
      d_addr     = '0;
      d_wdata    = '0;
      d_memwrite = 2'b00;
      m_rdata    = '0;
      m_ready    = 1'b0;

      // Reset values, and stallF combinational during reset.
      applyStimulus();
      applyStimulus();
      checkOutput("rst_m_req", m_req, 0);
      checkOutput("rst_m_be", m_be, 0);
      checkOutput("rst_m_addr", m_addr, 0);
      checkOutput("rst_i_valid", i_valid, 0);
      checkOutput("rst_d_valid", d_valid, 0);
      checkOutput("rst_i_rdata", i_rdata, 0);
      i_req  = 1'b1;
      i_addr = 32'h0000_0100;
      #1;
      checkOutput("rst_stallF", stallF, 1);

      // Reset mid-IACC with m_ready held low.
      reset = 1'b0;
      applyStimulus();
      checkOutput("iacc_m_req", m_req, 1);
      applyStimulus();
      checkOutput("iacc_hold_m_req", m_req, 1);
      reset = 1'b1;
      #1;
      checkOutput("async_m_req_drop", m_req, 0);
      i_req = 1'b0;
      #9;
      reset = 1'b0;
      applyStimulus();
      checkOutput("abort_no_i_valid", i_valid, 0);
      checkOutput("abort_idle_m_req", m_req, 0);

      // Single fetch from 0x4 with zero wait states.
      m_ready = 1'b1;
      m_rdata = 32'h2002_0005;
      i_req   = 1'b1;
      i_addr  = 32'h0000_0004;
      #1;
      checkOutput("f_t_stallF", stallF, 1);
      checkOutput("f_t_m_req", m_req, 0);
      applyStimulus();
      checkOutput("f_t1_m_req", m_req, 1);
      checkOutput("f_t1_m_addr", m_addr, 32'h0000_0004);
      checkOutput("f_t1_m_we", m_we, 0);
      checkOutput("f_t1_m_be", m_be, 4'b1111);
      checkOutput("f_t1_stallF", stallF, 1);
      checkOutput("f_t1_i_valid", i_valid, 0);
      applyStimulus();
      checkOutput("f_t2_i_valid", i_valid, 1);
      checkOutput("f_t2_i_rdata", i_rdata, 32'h2002_0005);
      checkOutput("f_t2_stallF", stallF, 0);
      i_req = 1'b0;
      applyStimulus();
      checkOutput("f_t3_i_valid", i_valid, 0);
      checkOutput("f_t3_m_req", m_req, 0);
      checkOutput("f_t3_i_rdata_hold", i_rdata, 32'h2002_0005);

      // Simultaneous fetch 0x8 and load 0x44: data wins, fetch follows.
      i_req      = 1'b1;
      i_addr     = 32'h0000_0008;
      d_req      = 1'b1;
      d_addr     = 32'h0000_0044;
      d_memwrite = 2'b00;
      m_rdata    = 32'h1111_2222;
      applyStimulus();
      checkOutput("arb_t1_m_addr", m_addr, 32'h0000_0044);
      checkOutput("arb_t1_m_we", m_we, 0);
      checkOutput("arb_t1_stallF", stallF, 1);
      checkOutput("arb_t1_stallM", stallM, 1);
      applyStimulus();
      checkOutput("arb_t2_d_valid", d_valid, 1);
      checkOutput("arb_t2_d_rdata", d_rdata, 32'h1111_2222);
      checkOutput("arb_t2_stallM", stallM, 0);
      checkOutput("arb_t2_stallF", stallF, 1);
      checkOutput("arb_t2_m_req", m_req, 0);
      d_req   = 1'b0;
      m_rdata = 32'h3333_4444;
      applyStimulus();
      checkOutput("arb_t3_m_req", m_req, 1);
      checkOutput("arb_t3_m_addr", m_addr, 32'h0000_0008);
      checkOutput("arb_t3_stallF", stallF, 1);
      checkOutput("arb_t3_d_valid", d_valid, 0);
      applyStimulus();
      checkOutput("arb_t4_i_valid", i_valid, 1);
      checkOutput("arb_t4_i_rdata", i_rdata, 32'h3333_4444);
      checkOutput("arb_t4_d_rdata_hold", d_rdata, 32'h1111_2222);
      i_req = 1'b0;
      applyStimulus();

      // Byte, half and word stores.
      d_req      = 1'b1;
      d_addr     = 32'h0000_0053;
      d_wdata    = 32'h0000_00AB;
      d_memwrite = 2'b11;
      applyStimulus();
      checkOutput("sb_m_be", m_be, 4'b1000);
      checkOutput("sb_m_wdata", m_wdata, 32'hABAB_ABAB);
      checkOutput("sb_m_we", m_we, 1);
      checkOutput("sb_m_addr", m_addr, 32'h0000_0050);
      applyStimulus();
      checkOutput("sb_d_valid", d_valid, 1);
      d_addr     = 32'h0000_0052;
      d_memwrite = 2'b10;
      applyStimulus();
      checkOutput("sh_gap_m_req", m_req, 0);
      applyStimulus();
      checkOutput("sh_m_be", m_be, 4'b1100);
      checkOutput("sh_m_wdata", m_wdata, 32'h00AB_00AB);
      applyStimulus();
      checkOutput("sh_d_valid", d_valid, 1);
      d_addr     = 32'h0000_0050;
      d_memwrite = 2'b01;
      d_wdata    = 32'h0000_0007;
      applyStimulus();
      applyStimulus();
      checkOutput("sw_m_be", m_be, 4'b1111);
      checkOutput("sw_m_we", m_we, 1);
      checkOutput("sw_m_wdata", m_wdata, 32'h0000_0007);
      applyStimulus();
      checkOutput("sw_d_valid", d_valid, 1);
      d_req = 1'b0;
      applyStimulus();

      // Load from 0x60 with three memory wait cycles.
      m_ready    = 1'b0;
      d_req      = 1'b1;
      d_addr     = 32'h0000_0060;
      d_memwrite = 2'b00;
      for (int w = 1; w <= 3; w++) begin
         applyStimulus();
         checkOutput($sformatf("wait%0d_m_req", w), m_req, 1);
         checkOutput($sformatf("wait%0d_m_addr", w), m_addr, 32'h0000_0060);
         checkOutput($sformatf("wait%0d_m_be", w), m_be, 4'b1111);
         checkOutput($sformatf("wait%0d_d_valid", w), d_valid, 0);
      end
      applyStimulus();
      m_ready = 1'b1;
      m_rdata = 32'hCAFE_F00D;
      #1;
      checkOutput("wait4_d_valid", d_valid, 0);
      checkOutput("wait4_stallM", stallM, 1);
      applyStimulus();
      checkOutput("wait5_d_valid", d_valid, 1);
      checkOutput("wait5_d_rdata", d_rdata, 32'hCAFE_F00D);
      d_req = 1'b0;
      applyStimulus();

      // Repeated fetch of 0x10, then store into that word and fetch again.
      m_rdata = 32'h0BAD_BEEF;
      i_req   = 1'b1;
      i_addr  = 32'h0000_0010;
      applyStimulus();
      checkOutput("bf1_m_req", m_req, 1);
      applyStimulus();
      checkOutput("bf1_i_valid", i_valid, 1);
      i_req = 1'b0;
      applyStimulus();
      m_rdata = 32'h0000_0000;
      i_req   = 1'b1;
      #1;
`ifdef ARB_IFETCH_BUF_EN
      checkOutput("bf2_hit_i_valid", i_valid, 1);
      checkOutput("bf2_hit_i_rdata", i_rdata, 32'h0BAD_BEEF);
      checkOutput("bf2_hit_stallF", stallF, 0);
      applyStimulus();
      checkOutput("bf2_no_m_req", m_req, 0);
      i_req = 1'b0;
      d_req      = 1'b1;
      d_addr     = 32'h0000_0012;
      d_memwrite = 2'b10;
      applyStimulus();
      checkOutput("bfst_m_addr", m_addr, 32'h0000_0010);
      applyStimulus();
      checkOutput("bfst_d_valid", d_valid, 1);
      d_req = 1'b0;
      applyStimulus();
      m_rdata = 32'h5555_AAAA;
      i_req   = 1'b1;
      #1;
      checkOutput("bf3_miss_i_valid", i_valid, 0);
      checkOutput("bf3_miss_stallF", stallF, 1);
      applyStimulus();
      checkOutput("bf3_m_req", m_req, 1);
      checkOutput("bf3_m_addr", m_addr, 32'h0000_0010);
      applyStimulus();
      checkOutput("bf3_i_rdata", i_rdata, 32'h5555_AAAA);
`else
      checkOutput("nb2_i_valid", i_valid, 0);
      checkOutput("nb2_stallF", stallF, 1);
      applyStimulus();
      checkOutput("nb2_m_req", m_req, 1);
      applyStimulus();
      checkOutput("nb2_i_valid_done", i_valid, 1);
      checkOutput("nb2_i_rdata", i_rdata, 32'h0000_0000);
`endif
      i_req = 1'b0;
      applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
